// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide control slice:
// sequencer state encoding and default step-count constants.
package muldiv_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam int MULT_STEPS_DEF = 32;
    localparam int DIV_STEPS_DEF  = 33;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/seq_step_counter.sv
// Falling-edge step counter: async clr, synchronous load-zero (wins over enable).
module seq_step_counter
    import muldiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_zero,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (load_zero) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/muldiv_step_sequencer.sv
// Turns ctrl_mult/ctrl_div start pulses into a bounded run of negedge step enables.
// Optional abort input is compiled in when SEQ_ABORT_EN is defined.
module muldiv_step_sequencer
    import muldiv_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             first_step,
    output logic             last_step,
    output logic             op_is_div,
    output logic             busy,
    output logic             result_rdy,
    output logic             illegal_op
);

    // state    | meaning
    // SEQ_IDLE | waiting for a single legal start pulse
    // SEQ_RUN  | issuing one step per cycle, step_idx 0..N-1
    // SEQ_DONE | one-cycle result_rdy; a new start may chain straight into RUN

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic             start_ok;
    logic             start_bad;
    logic             abort_hit;
    logic             at_last;
    logic             cnt_zero;
    logic [CNT_W-1:0] last_idx;

    assign start_ok  = ctrl_mult ^ ctrl_div;
    assign start_bad = ctrl_mult & ctrl_div;

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && (state != SEQ_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign last_idx = op_is_div ? DIV_LAST : MULT_LAST;
    assign at_last  = (step_idx == last_idx);

    always_comb begin
        state_nxt = state;
        cnt_zero  = 1'b1;
        case (state)
            SEQ_IDLE: begin
                if (start_ok) state_nxt = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (abort_hit)     state_nxt = SEQ_IDLE;
                else if (start_ok) state_nxt = SEQ_RUN;
                else if (at_last)  state_nxt = SEQ_DONE;
                else               cnt_zero  = 1'b0;
            end
            SEQ_DONE: begin
                if (abort_hit)     state_nxt = SEQ_IDLE;
                else if (start_ok) state_nxt = SEQ_RUN;
                else               state_nxt = SEQ_IDLE;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state      <= SEQ_IDLE;
            op_is_div  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_nxt;
            illegal_op <= start_bad;
            if (start_ok && !abort_hit) op_is_div <= ctrl_div;
        end
    end

    seq_step_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .load_zero(cnt_zero),
        .en       (step_en),
        .cnt      (step_idx)
    );

    assign step_en    = (state == SEQ_RUN);
    assign busy       = step_en;
    assign result_rdy = (state == SEQ_DONE);
    assign first_step = step_en && (step_idx == '0);
    assign last_step  = step_en && at_last;

endmodule
